// File: rtl/cache_write_buffer.sv
// Posted-write buffer between a cache and its memory controller. Writes drain
// in order; reads hit the youngest buffered copy or go to memory ahead of the drain.
module cache_write_buffer #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_rw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  req_done,
   output logic [WORD_WIDTH-1:0] resp_data,
   output logic                  mem_valid,
   output logic                  mem_rw,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [WORD_WIDTH-1:0] mem_rdata,
   output logic                  empty
);
   // state | meaning
   // IDLE  | no memory transaction outstanding
   // WRITE | head entry being written to memory
   // READ  | read miss outstanding at memory
   // RESP  | one-cycle read completion with memory data
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] buf_addr [DEPTH];
   logic [WORD_WIDTH-1:0] buf_data [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           count;
   logic                  hit_q;

   logic                  is_write, is_read, push, pop;
   logic                  read_eval, hit, hit_take, read_miss;
   logic [WORD_WIDTH-1:0] hit_data;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [WORD_WIDTH-1:0] head_data;

   assign is_write = req_valid & req_rw;
   assign is_read  = req_valid & ~req_rw;
   assign pop      = (state == WRITE) & mem_ack;
   // A full buffer still accepts a write in the cycle its head retires.
   assign push     = is_write & ((count != FULL) | pop);

   // hit_q blocks the pulse cycle so a held read is not answered twice
   assign read_eval = is_read & ~hit_q & ((state == IDLE) | (state == WRITE));
   assign hit_take  = read_eval & hit;
   assign read_miss = read_eval & ~hit & (state == IDLE);

   // Oldest to youngest so the last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PW+1)'(i) < count) && (buf_addr[rd_ptr + PW'(i)] == req_addr)) begin
            hit      = 1'b1;
            hit_data = buf_data[rd_ptr + PW'(i)];
         end
      end
   end

   // From empty, the entry being pushed this cycle becomes the head.
   assign head_addr = (count == '0) ? req_addr  : buf_addr[rd_ptr];
   assign head_data = (count == '0) ? req_wdata : buf_data[rd_ptr];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (read_miss)                     state_nxt = READ;
            else if ((count != '0) || push)    state_nxt = WRITE;
         end
         WRITE:   if (mem_ack) state_nxt = IDLE;
         READ:    if (mem_ack) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req_done = push | hit_q | (state == RESP);
   assign empty    = (count == '0) && (state != WRITE);

   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[wr_ptr] <= req_addr;
         buf_data[wr_ptr] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         hit_q     <= 1'b0;
         resp_data <= '0;
         mem_valid <= 1'b0;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nxt;
         hit_q <= hit_take;

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);

         if (hit_take)                      resp_data <= hit_data;
         else if ((state == READ) && mem_ack) resp_data <= mem_rdata;

         if ((state == IDLE) && (state_nxt == READ)) begin
            mem_valid <= 1'b1;
            mem_rw    <= 1'b0;
            mem_addr  <= req_addr;
            mem_wdata <= '0;
         end else if ((state == IDLE) && (state_nxt == WRITE)) begin
            mem_valid <= 1'b1;
            mem_rw    <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
         end else if (mem_ack && ((state == WRITE) || (state == READ))) begin
            mem_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: expected completions and memory
// requests are queued by the stimulus and checked by an independent monitor.
module tb_cache_write_buffer;
   localparam int WW = 32;
   localparam int AW = 12;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_rw = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [WW-1:0] req_wdata = '0;
   logic          req_done;
   logic [WW-1:0] resp_data;
   logic          mem_valid, mem_rw;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [WW-1:0] mem_rdata = '0;
   logic          empty;

   cache_write_buffer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
      .resp_data(resp_data), .mem_valid(mem_valid), .mem_rw(mem_rw),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .empty(empty)
   );

   always #5 clk = ~clk;

   // kind: 0 write, 1 read hit, 2 read from memory
   typedef struct { int kind; logic [WW-1:0] data; } comp_t;
   typedef struct { logic rw; logic [AW-1:0] addr; logic [WW-1:0] data; } mreq_t;
   comp_t exp_comp[$];
   mreq_t exp_mem[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_push = 0;
   logic auto_ack = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   // Monitor
   comp_t c;
   mreq_t m;
   logic ack_prev = 1'b0, mv_prev = 1'b0, rw_prev = 1'b0;
   logic [AW-1:0] addr_prev = '0;
   logic [WW-1:0] wd_prev = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (req_done) begin
            if (exp_comp.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got req_done=1 expected 0");
            end else begin
               c = exp_comp.pop_front();
               if (c.kind != 0) chk("resp_data", resp_data, c.data);
               if (c.kind == 2) chk("resp_after_ack", ack_prev, 1);
            end
         end
         if (mem_valid && !mv_prev) begin
            if (exp_mem.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_mem_req: got addr %0h expected none", mem_addr);
            end else begin
               m = exp_mem.pop_front();
               chk("mem_rw", mem_rw, m.rw);
               chk("mem_addr", mem_addr, m.addr);
               if (m.rw) chk("mem_wdata", mem_wdata, m.data);
            end
         end else if (mem_valid && mv_prev) begin
            chk("mem_stable", {mem_rw, mem_addr, mem_wdata}, {rw_prev, addr_prev, wd_prev});
         end
      end
      ack_prev  = mem_ack;
      mv_prev   = mem_valid;
      rw_prev   = mem_rw;
      addr_prev = mem_addr;
      wd_prev   = mem_wdata;
   end

   // Automatic memory responder: one-cycle ack to every request
   initial begin
      forever begin
         @(posedge clk); #1;
         if (auto_ack) begin
            if (mem_valid && !mem_ack) mem_ack = 1'b1;
            else                       mem_ack = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // All tasks start and end at posedge+1.
   task automatic do_write(input logic [AW-1:0] a, input logic [WW-1:0] d,
                           output int lat, output logic ack_seen);
      exp_comp.push_back('{0, '0});
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = d;
      lat = 0; ack_seen = 1'b0;
      while (1) begin
         @(negedge clk);
         if (req_done) begin ack_seen = mem_ack; break; end
         lat++;
         if (lat > 60) begin fail("write_done_wait"); break; end
      end
      n_push++;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [WW-1:0] d,
                          input int kind, output int lat);
      exp_comp.push_back('{kind, d});
      req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
      lat = 0;
      while (1) begin
         @(negedge clk);
         if (req_done) break;
         lat++;
         if (lat > 60) begin fail("read_done_wait"); break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic ack_once(input logic [WW-1:0] rd);
      int n = 0;
      @(negedge clk);
      while (!mem_valid && n < 60) begin @(negedge clk); n++; end
      if (!mem_valid) fail("mem_valid_wait");
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      auto_ack = 1'b1;
      @(negedge clk);
      while (!empty && n < 200) begin @(negedge clk); n++; end
      if (!empty) fail("empty_wait");
      auto_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   int lat;
   logic ack_seen;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_done", req_done, 0);
      chk("rst_empty", empty, 1);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_fields", {mem_rw, mem_addr, mem_wdata}, 0);
      chk("rst_resp_data", resp_data, 0);
      @(posedge clk); #1;

      // 1: single write from empty
      exp_mem.push_back('{1'b1, 12'h17C, 32'hDEADBEEF});
      do_write(12'h17C, 32'hDEADBEEF, lat, ack_seen);
      chk("s1_write_lat", lat, 0);
      @(negedge clk);
      chk("s1_mem_valid", mem_valid, 1);
      chk("s1_mem_rw", mem_rw, 1);
      chk("s1_mem_addr", mem_addr, 12'h17C);
      chk("s1_not_empty", empty, 0);
      @(posedge clk); #1;
      ack_once('0);
      @(negedge clk);
      chk("s1_empty", empty, 1);
      @(posedge clk); #1;

      // 2: full buffer stalls the fifth write until the first ack
      for (int i = 0; i < 5; i++) exp_mem.push_back('{1'b1, AW'(12'h200 + i), WW'(32'hA0 + i)});
      for (int i = 0; i < 4; i++) begin
         do_write(AW'(12'h200 + i), WW'(32'hA0 + i), lat, ack_seen);
         chk("s2_write_lat", lat, 0);
      end
      chk("s2_count_full", dut.count, 4);
      fork
         do_write(12'h204, 32'hA4, lat, ack_seen);
         begin repeat (3) @(posedge clk); #1; ack_once('0); end
      join
      chk("s2_stall_cycles", (lat >= 3), 1);
      chk("s2_done_with_ack", ack_seen, 1);
      @(negedge clk);
      chk("s2_count_stays", dut.count, 4);
      @(posedge clk); #1;
      wait_empty();

      // 3: read hit returns the youngest duplicate, no memory read
      exp_mem.push_back('{1'b1, 12'h010, 32'h1});
      exp_mem.push_back('{1'b1, 12'h010, 32'h2});
      do_write(12'h010, 32'h1, lat, ack_seen);
      do_write(12'h010, 32'h2, lat, ack_seen);
      chk("s3_count_dup", dut.count, 2);
      do_read(12'h010, 32'h2, 1, lat);
      chk("s3_hit_lat", lat, 1);
      chk("s3_no_mem_read", mem_rw, 1);
      wait_empty();

      // 4: read miss jumps ahead of the remaining drain
      exp_mem.push_back('{1'b1, 12'h030, 32'h11});
      exp_mem.push_back('{1'b0, 12'h020, 32'h0});
      exp_mem.push_back('{1'b1, 12'h031, 32'h22});
      do_write(12'h030, 32'h11, lat, ack_seen);
      do_write(12'h031, 32'h22, lat, ack_seen);
      fork
         do_read(12'h020, 32'hCAFEF00D, 2, lat);
         begin ack_once('0); ack_once(32'hCAFEF00D); end
      join
      chk("s4_count_after_read", dut.count, 1);
      wait_empty();

      // 5: simultaneous push and pop, then pointer wrap over 8 writes
      exp_mem.push_back('{1'b1, 12'h0A0, 32'h50});
      exp_mem.push_back('{1'b1, 12'h0A1, 32'h51});
      exp_mem.push_back('{1'b1, 12'h0A2, 32'h52});
      for (int i = 0; i < 8; i++) exp_mem.push_back('{1'b1, AW'(12'h100 + i), WW'(32'h1000 + i)});
      do_write(12'h0A0, 32'h50, lat, ack_seen);
      do_write(12'h0A1, 32'h51, lat, ack_seen);
      exp_comp.push_back('{0, '0});
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h0A2; req_wdata = 32'h52;
      mem_ack = 1'b1;
      @(negedge clk);
      chk("s5_pushpop_done", req_done, 1);
      chk("s5_count_before", dut.count, 2);
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ack = 1'b0;
      n_push++;
      @(negedge clk);
      chk("s5_count_after", dut.count, 2);
      @(posedge clk); #1;
      auto_ack = 1'b1;
      for (int i = 0; i < 8; i++) do_write(AW'(12'h100 + i), WW'(32'h1000 + i), lat, ack_seen);
      wait_empty();
      chk("s5_wr_ptr", dut.wr_ptr, n_push % DEPTH);
      chk("s5_rd_ptr", dut.rd_ptr, n_push % DEPTH);

      // 6: reset while a read is outstanding with three entries buffered
      exp_mem.push_back('{1'b1, 12'h050, 32'h60});
      exp_mem.push_back('{1'b0, 12'h040, 32'h0});
      for (int i = 0; i < 4; i++) do_write(AW'(12'h050 + i), WW'(32'h60 + i), lat, ack_seen);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h040;
      ack_once('0);
      begin
         int n = 0;
         @(negedge clk);
         while (!(mem_valid && !mem_rw) && n < 20) begin @(negedge clk); n++; end
         if (!(mem_valid && !mem_rw)) fail("s6_read_issue");
      end
      chk("s6_count_in_read", dut.count, 3);
      @(posedge clk); #1;
      rst = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("s6_mem_valid", mem_valid, 0);
      chk("s6_empty", empty, 1);
      chk("s6_count", dut.count, 0);
      chk("s6_wr_ptr", dut.wr_ptr, 0);
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s6_no_late_done", req_done, 0);
         chk("s6_idle_mem", mem_valid, 0);
      end

      chk("comp_queue_drained", exp_comp.size(), 0);
      chk("mem_queue_drained", exp_mem.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
